// File: rtl/xdma_ctrl_pkg.sv
// Shared widths, config register map, STATUS bit positions and FSM encoding for xdma_ctrl.
package xdma_ctrl_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] XDMA_SRC    = 2'd0;
    localparam logic [1:0] XDMA_DST    = 2'd1;
    localparam logic [1:0] XDMA_LEN    = 2'd2;
    localparam logic [1:0] XDMA_STATUS = 2'd3;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_DONE = 1;
    localparam int unsigned ST_ERR  = 2;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/xdma_ctrl.sv
// Word-copy DMA initiator on the sel-based system bus, programmed through a 4-register config port.
// Optional XDMA_FILL_EN: LEN[DATA_W-1] selects fill mode (SRC value written to every DST word).
module xdma_ctrl
    import xdma_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_sel,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [DATA_W-1:0] cfg_data_in,
    output logic [DATA_W-1:0] cfg_data_out,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              sel,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data_to_wr,
    input  logic [DATA_W-1:0] data_to_rd,
    input  logic              trap,
    output logic              busy
);

    state_t            state, state_nxt;
    logic [DATA_W-1:0] src, src_nxt, dst, dst_nxt;
    logic [LEN_W-1:0]  count, count_nxt;
    logic              fill, fill_nxt;
    logic              done, done_nxt, err, err_nxt;
    logic              bus_req_nxt, sel_nxt, we_nxt, busy_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              idle, cfg_wr, start, trap_hit, word_done, active;

    // Next-state, register updates and next registered outputs
    always_comb begin
        state_nxt = state;
        src_nxt   = src;
        dst_nxt   = dst;
        count_nxt = count;
        fill_nxt  = fill;
        done_nxt  = done;
        err_nxt   = err;

        idle      = (state == S_IDLE) || (state == S_DONE);
        cfg_wr    = cfg_sel && cfg_we;
        start     = cfg_wr && idle && (cfg_addr == XDMA_LEN);
        trap_hit  = trap && ((state == S_RD) || (state == S_WR));
        word_done = (state == S_WR) && !trap;

        if (cfg_wr && idle && (cfg_addr == XDMA_SRC)) src_nxt = cfg_data_in;
        if (cfg_wr && idle && (cfg_addr == XDMA_DST)) dst_nxt = cfg_data_in;
        if (start) begin
            count_nxt = cfg_data_in[LEN_W-1:0];
`ifdef XDMA_FILL_EN
            fill_nxt  = cfg_data_in[DATA_W-1];
`else
            fill_nxt  = 1'b0;
`endif
        end
        if (word_done) begin
            if (!fill) src_nxt = src + DATA_W'(1);
            dst_nxt   = dst + DATA_W'(1);
            count_nxt = count - LEN_W'(1);
        end

        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) state_nxt = (cfg_data_in[LEN_W-1:0] == '0) ? S_DONE : S_REQ;
                else       state_nxt = S_IDLE;
            end
            S_REQ: if (bus_gnt) state_nxt = fill ? S_WR : S_RD;
            S_RD:  state_nxt = trap ? S_IDLE : S_CAP;
            S_CAP: state_nxt = S_WR;
            S_WR: begin
                if (trap)                    state_nxt = S_IDLE;
                else if (count > LEN_W'(1))  state_nxt = fill ? S_WR : S_RD;
                else                         state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Software clear first so a same-cycle hardware event still wins
        if (cfg_wr && (cfg_addr == XDMA_STATUS)) begin
            if (cfg_data_in[ST_DONE]) done_nxt = 1'b0;
            if (cfg_data_in[ST_ERR])  err_nxt  = 1'b0;
        end
        if ((state_nxt == S_DONE) || trap_hit) done_nxt = 1'b1;
        if (trap_hit) err_nxt = 1'b1;

        active      = (state_nxt == S_REQ) || (state_nxt == S_RD) ||
                      (state_nxt == S_CAP) || (state_nxt == S_WR);
        bus_req_nxt = active;
        busy_nxt    = active;
        sel_nxt     = (state_nxt == S_RD) || (state_nxt == S_WR);
        we_nxt      = (state_nxt == S_WR);
        addr_nxt    = '0;
        if (state_nxt == S_RD) addr_nxt = src_nxt[ADDR_W-1:0];
        if (state_nxt == S_WR) addr_nxt = dst_nxt[ADDR_W-1:0];
        data_nxt    = data_to_wr;
        if (state == S_CAP)                data_nxt = data_to_rd;
        if (fill && (state_nxt == S_WR))   data_nxt = src_nxt;
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            src        <= '0;
            dst        <= '0;
            count      <= '0;
            fill       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            bus_req    <= 1'b0;
            sel        <= 1'b0;
            we         <= 1'b0;
            addr       <= '0;
            data_to_wr <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            src        <= src_nxt;
            dst        <= dst_nxt;
            count      <= count_nxt;
            fill       <= fill_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            bus_req    <= bus_req_nxt;
            sel        <= sel_nxt;
            we         <= we_nxt;
            addr       <= addr_nxt;
            data_to_wr <= data_nxt;
            busy       <= busy_nxt;
        end
    end

    // Config read mux, combinational from cfg_addr
    always_comb begin
        cfg_data_out = '0;
        unique case (cfg_addr)
            XDMA_SRC: cfg_data_out = src;
            XDMA_DST: cfg_data_out = dst;
            XDMA_LEN: cfg_data_out = DATA_W'(count);
            default: begin
                cfg_data_out[ST_BUSY] = busy;
                cfg_data_out[ST_DONE] = done;
                cfg_data_out[ST_ERR]  = err;
            end
        endcase
    end

endmodule

// File: tb/tb_xdma_ctrl.sv
// Self-checking bench for xdma_ctrl: bus memory/decoder/arbiter environment plus a transfer-level model.
module tb_xdma_ctrl;

    localparam int unsigned AW = xdma_ctrl_pkg::ADDR_W;
    localparam int unsigned DW = xdma_ctrl_pkg::DATA_W;
    localparam logic [1:0] R_SRC = 2'd0, R_DST = 2'd1, R_LEN = 2'd2, R_STAT = 2'd3;

    logic          clk, rst;
    logic          cfg_sel, cfg_we;
    logic [1:0]    cfg_addr;
    logic [DW-1:0] cfg_data_in, cfg_data_out;
    logic          bus_req, bus_gnt, sel, we, trap, busy;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_to_wr, data_to_rd;

    xdma_ctrl #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .cfg_sel(cfg_sel), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data_in(cfg_data_in), .cfg_data_out(cfg_data_out),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .sel(sel), .we(we), .addr(addr),
        .data_to_wr(data_to_wr), .data_to_rd(data_to_rd),
        .trap(trap), .busy(busy)
    );

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    logic [DW-1:0] mem     [0:65535];
    logic [DW-1:0] exp_mem [0:65535];
    acc_t          exp_q[$];

    int nchk, nerr, cyc;
    int sel_total, rd_total, busy_total;
    int run_id, seen_id, first_sel, last_sel;
    int gnt_delay, unmap_lo, unmap_hi;
    int sel0, rd0, busy0, exp_n;
    bit trapped_exp, exp_fill;
    logic [DW-1:0] cur_d;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    function automatic bit unmapped(input logic [AW-1:0] a);
        return (int'(a) >= unmap_lo) && (int'(a) <= unmap_hi);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        nchk++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %h required %h at cycle %0d", name, act, exp_v, cyc);
        end
    endtask

    // Arbiter: grant gnt_delay cycles after request, release when request drops
    initial begin
        int wcnt;
        bus_gnt = 1'b0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (!bus_req) begin
                bus_gnt = 1'b0;
                wcnt = 0;
            end else if (wcnt >= gnt_delay) bus_gnt = 1'b1;
            else wcnt++;
        end
    end

    // Decoder + memory: trap on unmapped, read data valid the cycle after the strobe
    initial begin
        logic [AW-1:0] rd_addr;
        bit rd_pend;
        rd_pend = 1'b0;
        rd_addr = '0;
        trap = 1'b0;
        data_to_rd = '0;
        forever begin
            @(negedge clk);
            trap = sel && unmapped(addr);
            if (!rst && sel && !trap) begin
                if (we) mem[addr] = data_to_wr;
                else begin
                    rd_addr = addr;
                    rd_pend = 1'b1;
                    data_to_rd = $urandom;
                end
            end
            @(posedge clk);
            #1;
            if (rd_pend) begin
                data_to_rd = mem[rd_addr];
                rd_pend = 1'b0;
            end
        end
    end

    // Per-cycle compare of every bus access against the expected access list
    initial begin
        acc_t e;
        seen_id = 0;
        first_sel = 0;
        last_sel = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (busy) busy_total++;
                if (sel) begin
                    sel_total++;
                    if (!we) rd_total++;
                    if (seen_id != run_id) begin
                        seen_id = run_id;
                        first_sel = cyc;
                    end
                    last_sel = cyc;
                    chk("sel_needs_grant", {30'd0, bus_req, bus_gnt}, 32'd3);
                    if (exp_q.size() == 0) chk("unexpected_access", 32'(sel), 32'd0);
                    else begin
                        e = exp_q.pop_front();
                        chk("acc_we", 32'(we), 32'(e.w));
                        chk("acc_addr", 32'(addr), 32'(e.a));
                        if (e.w) chk("acc_data", data_to_wr, e.d);
                    end
                end
            end
        end
    end

    task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        cfg_sel = 1'b1;
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_data_in = d;
        @(negedge clk);
        cfg_sel = 1'b0;
        cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_data_out;
    endtask

    // Program a transfer and build the expected access list / memory image
    task automatic start_xfer(input logic [31:0] s, input logic [31:0] d,
                              input logic [31:0] l, input int gd);
        gnt_delay = gd;
        cfg_write(R_STAT, 32'h6);
        cfg_write(R_SRC, s);
        cfg_write(R_DST, d);
`ifdef XDMA_FILL_EN
        exp_fill = l[31];
`else
        exp_fill = 1'b0;
`endif
        exp_n = int'(l[15:0]);
        cur_d = d;
        trapped_exp = 1'b0;
        for (int i = 0; i < exp_n; i++) begin
            logic [AW-1:0] ra, wa;
            logic [DW-1:0] dv;
            ra = AW'(s + 32'(i));
            wa = AW'(d + 32'(i));
            if (!exp_fill) begin
                exp_q.push_back('{w: 1'b0, a: ra, d: '0});
                if (unmapped(ra)) begin
                    trapped_exp = 1'b1;
                    break;
                end
                dv = exp_mem[ra];
            end else dv = s;
            exp_q.push_back('{w: 1'b1, a: wa, d: dv});
            if (unmapped(wa)) begin
                trapped_exp = 1'b1;
                break;
            end
            exp_mem[wa] = dv;
        end
        run_id++;
        sel0 = sel_total;
        rd0 = rd_total;
        busy0 = busy_total;
        cfg_write(R_LEN, l);
    endtask

    task automatic finish_xfer();
        logic [31:0] st;
        int mism;
        st = '0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            cfg_read(R_STAT, st);
            if (st[0] == 1'b0) break;
        end
        chk("busy_cleared", 32'(st[0]), 32'd0);
        repeat (2) @(negedge clk);
        cfg_read(R_STAT, st);
        chk("status_end", st, {29'd0, trapped_exp, 1'b1, 1'b0});
        chk("bus_req_end", 32'(bus_req), 32'd0);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        mism = 0;
        for (int i = -1; i <= exp_n; i++) begin
            logic [AW-1:0] a;
            a = AW'(cur_d + 32'(i));
            if (mem[a] !== exp_mem[a]) mism++;
        end
        chk("mem_range", 32'(mism), 32'd0);
        if (exp_n > 0 && !trapped_exp)
            chk("bus_span", 32'(last_sel - first_sel + 1), 32'(exp_fill ? exp_n : 3 * exp_n));
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] st;
        int wc;
        nchk = 0; nerr = 0; cyc = 0;
        sel_total = 0; rd_total = 0; busy_total = 0; run_id = 0;
        gnt_delay = 0; unmap_lo = 1; unmap_hi = 0;
        rst = 1'b1;
        cfg_sel = 1'b0; cfg_we = 1'b0; cfg_addr = 2'd0; cfg_data_in = '0;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 32'hA000_0000 | 32'(i);
            exp_mem[i] = mem[i];
        end
        @(negedge clk);
        chk("rst_outputs", {26'd0, sel, we, bus_req, busy, |addr, |data_to_wr}, 32'd0);
        cfg_read(R_STAT, st);
        chk("rst_status", st, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: plain copy, late grant
        start_xfer(32'h10, 32'h40, 32'd4, 2);
        finish_xfer();
        chk("t1_mem40", mem[16'h40], 32'hA000_0010);
        chk("t1_mem43", mem[16'h43], 32'hA000_0013);
        chk("t1_span", 32'(last_sel - first_sel + 1), 32'd12);

        // 2: zero length
        start_xfer(32'h10, 32'h48, 32'd0, 0);
        cfg_read(R_STAT, st);
        chk("t2_status_next", st, 32'h2);
        finish_xfer();
        chk("t2_no_sel", 32'(sel_total - sel0), 32'd0);
        chk("t2_no_busy", 32'(busy_total - busy0), 32'd0);

        // 3: read from unmapped source traps
        unmap_lo = 32'h12; unmap_hi = 32'h12;
        start_xfer(32'h12, 32'h60, 32'd3, 1);
        finish_xfer();
        cfg_read(R_STAT, st);
        chk("t3_status", st, 32'h6);
        chk("t3_one_access", 32'(sel_total - sel0), 32'd1);
        chk("t3_dst_untouched", mem[16'h60], 32'hA000_0060);
        unmap_lo = 1; unmap_hi = 0;

        // 4: config writes while busy are ignored
        start_xfer(32'h20, 32'h80, 32'd5, 1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sel) break;
        end
        cfg_write(R_SRC, 32'h99);
        cfg_write(R_LEN, 32'd7);
        cfg_write(R_DST, 32'h1234);
        finish_xfer();
        cfg_read(R_SRC, st);
        chk("t4_src_final", st, 32'h25);
        cfg_read(R_DST, st);
        chk("t4_dst_final", st, 32'h85);
        cfg_write(R_STAT, 32'h6);
        cfg_read(R_STAT, st);
        chk("t4_status_clr", st, 32'h0);

        // 5: destination address wrap
        start_xfer(32'h30, 32'hFFFF, 32'd2, 0);
        finish_xfer();
        chk("t5_wrap_top", mem[16'hFFFF], 32'hA000_0030);
        chk("t5_wrap_zero", mem[16'h0000], 32'hA000_0031);

        // 6: async reset during the second write
        start_xfer(32'hC000, 32'hC100, 32'd4, 0);
        wc = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (sel && we) wc++;
            if (wc == 2) break;
        end
        chk("t6_wr2_seen", 32'(wc), 32'd2);
        rst = 1'b1;
        #1;
        chk("t6_async_rst", {28'd0, sel, we, bus_req, busy}, 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cfg_read(R_STAT, st);
        chk("t6_status_rst", st, 32'd0);
        cfg_read(R_SRC, st);
        chk("t6_src_rst", st, 32'd0);

`ifdef XDMA_FILL_EN
        start_xfer(32'hA5, 32'h50, 32'h8000_0003, 1);
        finish_xfer();
        chk("fill_w0", mem[16'h50], 32'hA5);
        chk("fill_w2", mem[16'h52], 32'hA5);
        chk("fill_no_reads", 32'(rd_total - rd0), 32'd0);
`else
        start_xfer(32'h18, 32'h50, 32'h8000_0003, 1);
        finish_xfer();
        chk("len_msb_ignored", mem[16'h52], 32'hA000_001A);
        chk("len_msb_reads", 32'(rd_total - rd0), 32'd3);
`endif

        // Randomized transfers, occasionally with an unmapped address in range
        for (int t = 0; t < 12; t++) begin
            logic [31:0] s, d, l;
            s = 32'($urandom_range(32'h100, 32'h3F00));
            d = 32'($urandom_range(32'h4000, 32'h7F00));
            l = 32'($urandom_range(1, 8));
            unmap_lo = 1; unmap_hi = 0;
            if ($urandom_range(0, 3) == 0) begin
                unmap_lo = ($urandom_range(0, 1) == 0) ? int'(s) : int'(d);
                unmap_lo = unmap_lo + int'($urandom_range(0, int'(l) - 1));
                unmap_hi = unmap_lo;
            end
`ifdef XDMA_FILL_EN
            if ($urandom_range(0, 2) == 0) l = l | 32'h8000_0000;
`endif
            start_xfer(s, d, l, int'($urandom_range(0, 3)));
            finish_xfer();
        end
        unmap_lo = 1; unmap_hi = 0;

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
